// File: rtl/cdc_handshake_rx_multi.sv
// cdc_handshake_rx_multi: multi-channel toggle REQ/ACK receive endpoint.
// Optional per-channel watchdog is built when CDC_HS_RX_TIMEOUT_EN is defined.
module cdc_handshake_rx_multi #(
   parameter  int NUM_CH         = 4,
   parameter  int DATA_W         = 8,
   parameter  int SYNC_STAGES    = 2,
   parameter  int TIMEOUT_CYCLES = 255,
   localparam int CW             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk_dst,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        req_toggle_i,
   input  logic [NUM_CH*DATA_W-1:0] data_i,
   output logic [NUM_CH-1:0]        ack_toggle_o,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CW-1:0]            out_chan,
   output logic [DATA_W-1:0]        out_data,
   output logic [NUM_CH-1:0]        pending_o,
   output logic [NUM_CH-1:0]        overrun_o,
   output logic [NUM_CH-1:0]        timeout_o,
   input  logic [NUM_CH-1:0]        timeout_clr_i
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_HELD = 2'd2
   } st_t;

   logic [SYNC_STAGES-1:0] r_sync [NUM_CH];
   logic [NUM_CH-1:0]      r_hist;
   logic [NUM_CH-1:0]      w_sync_q;
   logic [NUM_CH-1:0]      w_event;

   st_t                    r_st     [NUM_CH];
   st_t                    w_st_nxt [NUM_CH];
   logic [NUM_CH-1:0]      w_pend;
   logic [NUM_CH-1:0]      w_ovr_set;
   logic [NUM_CH-1:0]      r_ovr;
   logic [NUM_CH-1:0]      r_ack;

   logic                   r_full;
   logic [CW-1:0]          r_chan;
   logic [DATA_W-1:0]      r_data;
   logic [CW-1:0]          r_ptr;

   logic                   w_acc;
   logic                   w_load;
   logic                   w_gnt_vld;
   logic [CW-1:0]          w_gnt_idx;
   logic [CW-1:0]          w_ptr_nxt;
   int                     w_cand;

   // Toggle synchronizers plus one history flop for edge detection
   always_ff @(posedge clk_dst or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_sync[i] <= '0;
         end
         r_hist <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], req_toggle_i[i]};
         end
         r_hist <= w_sync_q;
      end
   end

   always_comb begin
      w_sync_q = '0;
      w_pend   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_sync_q[i] = r_sync[i][SYNC_STAGES-1];
         w_pend[i]   = (r_st[i] == ST_PEND);
      end
      w_event = w_sync_q ^ r_hist;
   end

   assign w_acc = r_full & out_ready;

   // Round-robin search starting at r_ptr; lowest offset wins
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      w_cand    = 0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         w_cand = (int'(r_ptr) + k) % NUM_CH;
         if (w_pend[w_cand]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = CW'(w_cand);
         end
      end
      w_ptr_nxt = CW'((int'(w_gnt_idx) + 1) % NUM_CH);
   end

   assign w_load = w_gnt_vld & (~r_full | out_ready);

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         w_st_nxt[i]  = r_st[i];
         w_ovr_set[i] = 1'b0;
         unique case (r_st[i])
            ST_IDLE: begin
               if (w_event[i]) begin
                  w_st_nxt[i] = ST_PEND;
               end
            end
            ST_PEND: begin
               w_ovr_set[i] = w_event[i];
               if (w_load && (w_gnt_idx == CW'(i))) begin
                  w_st_nxt[i] = ST_HELD;
               end
            end
            ST_HELD: begin
               w_ovr_set[i] = w_event[i];
               if (w_acc && (r_chan == CW'(i))) begin
                  w_st_nxt[i] = ST_IDLE;
               end
            end
            default: w_st_nxt[i] = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_dst or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_st[i] <= ST_IDLE;
         end
         r_ovr <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_st[i] <= w_st_nxt[i];
         end
         r_ovr <= r_ovr | w_ovr_set;
      end
   end

   // Output register; reloads on the accept edge for back-to-back words
   always_ff @(posedge clk_dst or posedge rst) begin
      if (rst) begin
         r_full <= 1'b0;
         r_chan <= '0;
         r_data <= '0;
         r_ptr  <= '0;
         r_ack  <= '0;
      end else begin
         if (w_load) begin
            r_full <= 1'b1;
            r_chan <= w_gnt_idx;
            r_data <= data_i[int'(w_gnt_idx)*DATA_W +: DATA_W];
            r_ptr  <= w_ptr_nxt;
         end else if (w_acc) begin
            r_full <= 1'b0;
         end
         if (w_acc) begin
            r_ack[r_chan] <= ~r_ack[r_chan];
         end
      end
   end

   assign ack_toggle_o = r_ack;
   assign out_valid    = r_full;
   assign out_chan     = r_chan;
   assign out_data     = r_data;
   assign pending_o    = w_pend;
   assign overrun_o    = r_ovr;

`ifdef CDC_HS_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0]     r_cnt [NUM_CH];
   logic [NUM_CH-1:0] r_to;

   // Flag fires only on the cycle the count reaches the limit
   always_ff @(posedge clk_dst or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_cnt[i] <= '0;
         end
         r_to <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (r_st[i] == ST_IDLE) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] != TW'(TIMEOUT_CYCLES)) begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
            if ((r_st[i] != ST_IDLE) &&
                (r_cnt[i] == TW'(TIMEOUT_CYCLES - 1))) begin
               r_to[i] <= 1'b1;
            end else if (timeout_clr_i[i]) begin
               r_to[i] <= 1'b0;
            end
         end
      end
   end

   assign timeout_o = r_to;
`else
   logic w_unused_clr;

   assign w_unused_clr = ^timeout_clr_i;
   assign timeout_o    = '0;
`endif

endmodule

// File: tb/tb_cdc_handshake_rx_multi.sv
// tb_cdc_handshake_rx_multi: scoreboard bench for the toggle CDC receiver.
// Randomized source/consumer traffic plus directed corner cases.
module tb_cdc_handshake_rx_multi;

   localparam int NCH = 4;
   localparam int DW  = 8;
   localparam int SS  = 2;
   localparam int TO  = 16;

   logic              clk_dst = 1'b0;
   logic              rst = 1'b0;
   logic [NCH-1:0]    req_toggle_i = '0;
   logic [NCH*DW-1:0] data_i = '0;
   logic [NCH-1:0]    ack_toggle_o;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [1:0]        out_chan;
   logic [DW-1:0]     out_data;
   logic [NCH-1:0]    pending_o;
   logic [NCH-1:0]    overrun_o;
   logic [NCH-1:0]    timeout_o;
   logic [NCH-1:0]    timeout_clr_i = '0;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [DW-1:0]  exp_q [NCH][$];
   logic [NCH-1:0] ack_exp = '0;
   int             acc_log [$];
   int             acc_cyc [$];

   cdc_handshake_rx_multi #(
      .NUM_CH(NCH), .DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_dst(clk_dst), .rst(rst),
      .req_toggle_i(req_toggle_i), .data_i(data_i),
      .ack_toggle_o(ack_toggle_o),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_chan(out_chan), .out_data(out_data),
      .pending_o(pending_o), .overrun_o(overrun_o),
      .timeout_o(timeout_o), .timeout_clr_i(timeout_clr_i)
   );

   always #5 clk_dst = ~clk_dst;
   always @(posedge clk_dst) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk_dst);
      #2;
   endtask

   function automatic int sb_left();
      int n = 0;
      for (int i = 0; i < NCH; i++) n += exp_q[i].size();
      return n;
   endfunction

   // Source side: present data, flip toggle, record what must come out
   task automatic issue(input int ch, input logic [DW-1:0] d);
      data_i[ch*DW +: DW] = d;
      exp_q[ch].push_back(d);
      req_toggle_i[ch] = ~req_toggle_i[ch];
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while ((sb_left() != 0 || ack_toggle_o !== req_toggle_i) && n < budget) begin
         tick();
         n++;
      end
      check(name, 64'(sb_left()), 64'd0);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check(name, 64'(out_valid), 64'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_toggle_i = '0;
      data_i = '0;
      out_ready = 1'b0;
      timeout_clr_i = '0;
      ack_exp = '0;
      for (int i = 0; i < NCH; i++) exp_q[i].delete();
      repeat (3) @(posedge clk_dst);
      #2;
      rst = 1'b0;
      tick();
   endtask

   // Monitor: pops the scoreboard on every accept, checks holds under stall
   initial begin
      logic           prev_hold;
      logic [1:0]     prev_ch;
      logic [DW-1:0]  prev_d;
      int             ch;
      logic [DW-1:0]  d;
      prev_hold = 1'b0;
      prev_ch = '0;
      prev_d = '0;
      forever begin
         @(negedge clk_dst);
         if (rst) begin
            prev_hold = 1'b0;
         end else begin
            if (prev_hold) begin
               check("hold_valid", 64'(out_valid), 64'd1);
               check("hold_chan", 64'(out_chan), 64'(prev_ch));
               check("hold_data", 64'(out_data), 64'(prev_d));
            end
            prev_hold = out_valid && !out_ready;
            prev_ch = out_chan;
            prev_d = out_data;
            if (out_valid && out_ready) begin
               ch = int'(out_chan);
               d = out_data;
               @(posedge clk_dst);
               #1;
               if (!rst) begin
                  ack_exp[ch] = ~ack_exp[ch];
                  acc_log.push_back(ch);
                  acc_cyc.push_back(cyc);
                  if (exp_q[ch].size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL sb_unexpected: got ch%0d data %0h required no word",
                              ch, d);
                  end else begin
                     check("sb_data", 64'(d), 64'(exp_q[ch].pop_front()));
                  end
                  check("ack_flip", 64'(ack_toggle_o), 64'(ack_exp));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int            n;
      logic [NCH-1:0] snap;
      logic [DW-1:0]  d;
      int            c;

      #1 rst = 1'b1;
      #1;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_ack", 64'(ack_toggle_o), 64'd0);
      check("rst_pend", 64'(pending_o), 64'd0);
      check("rst_ovr", 64'(overrun_o), 64'd0);
      check("rst_to", 64'(timeout_o), 64'd0);
      check("rst_data", 64'({out_chan, out_data}), 64'd0);
      do_reset();

      // Single request with pending latency
      out_ready = 1'b1;
      issue(0, 8'hA5);
      n = 0;
      while (pending_o[0] !== 1'b1 && n < 8) begin
         @(posedge clk_dst);
         #1;
         n++;
      end
      check("pend_latency_ok", 64'(n >= SS && n <= SS + 2), 64'd1);
      @(posedge clk_dst);
      #1;
      check("single_valid", 64'(out_valid), 64'd1);
      check("single_chan", 64'(out_chan), 64'd0);
      check("single_data", 64'(out_data), 64'hA5);
      check("single_pend_clr", 64'(pending_o[0]), 64'd0);
      repeat (3) tick();
      check("single_ack", 64'(ack_toggle_o), 64'd1);
      check("single_sb", 64'(sb_left()), 64'd0);

      // All channels at once: round-robin 0..3 back-to-back
      do_reset();
      out_ready = 1'b1;
      acc_log.delete();
      acc_cyc.delete();
      for (int i = 0; i < NCH; i++) issue(i, 8'($urandom));
      n = 0;
      while (acc_log.size() < NCH && n < 30) begin
         tick();
         n++;
      end
      check("all_count", 64'(acc_log.size()), 64'(NCH));
      for (int i = 0; i < NCH && i < acc_log.size(); i++) begin
         check("all_order", 64'(acc_log[i]), 64'(i));
         check("all_nobubble", 64'(acc_cyc[i] - acc_cyc[0]), 64'(i));
      end
      repeat (2) tick();
      check("all_acks", 64'(ack_toggle_o), 64'hF);

      // Backpressure on channel 2
      out_ready = 1'b0;
      issue(2, 8'($urandom));
      wait_valid("bp_valid");
      snap = ack_toggle_o;
      repeat (10) tick();
      check("bp_chan", 64'(out_chan), 64'd2);
      check("bp_noack", 64'(ack_toggle_o), 64'(snap));
      out_ready = 1'b1;
      @(posedge clk_dst);
      #1;
      check("bp_release_ack", 64'(ack_toggle_o), 64'(snap ^ 4'b0100));
      tick();
      check("bp_empty", 64'(out_valid), 64'd0);

      // Randomized traffic with random backpressure
      for (int it = 0; it < 400; it++) begin
         out_ready = ($urandom % 4) != 0;
         c = int'($urandom % NCH);
         if (ack_toggle_o[c] == req_toggle_i[c] && ($urandom % 2) == 0)
            issue(c, 8'($urandom));
         tick();
      end
      out_ready = 1'b1;
      drain("rand_drain", 200);
      check("rand_acks", 64'(ack_toggle_o), 64'(req_toggle_i));
      check("rand_no_ovr", 64'(overrun_o), 64'd0);
`ifndef CDC_HS_RX_TIMEOUT_EN
      timeout_clr_i = 4'hF;
      tick();
      timeout_clr_i = '0;
      check("to_tied", 64'(timeout_o), 64'd0);
`endif

      // Overrun: second toggle on channel 1 before its ACK
      out_ready = 1'b0;
      d = 8'($urandom);
      issue(1, d);
      n = 0;
      while (pending_o[1] !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      check("ovr_pend", 64'(pending_o[1]), 64'd1);
      req_toggle_i[1] = ~req_toggle_i[1];
      issue(3, 8'($urandom));
      repeat (SS + 3) tick();
      check("ovr_flag", 64'(overrun_o), 64'b0010);
      out_ready = 1'b1;
      n = 0;
      while (sb_left() != 0 && n < 40) begin
         tick();
         n++;
      end
      repeat (8) tick();
      check("ovr_sb", 64'(sb_left()), 64'd0);
      check("ovr_idle", 64'({out_valid, pending_o}), 64'd0);
      check("ovr_sticky", 64'(overrun_o), 64'b0010);

      // Reset while a word is held
      out_ready = 1'b0;
      issue(2, 8'($urandom));
      wait_valid("rmt_valid");
      rst = 1'b1;
      req_toggle_i = '0;
      #1;
      check("rmt_outs", 64'({out_valid, out_chan, out_data}), 64'd0);
      check("rmt_flags", 64'({ack_toggle_o, pending_o, overrun_o, timeout_o}), 64'd0);
      for (int i = 0; i < NCH; i++) exp_q[i].delete();
      ack_exp = '0;
      repeat (3) @(posedge clk_dst);
      #2;
      rst = 1'b0;
      repeat (6) tick();
      check("rmt_quiet", 64'({out_valid, pending_o, ack_toggle_o}), 64'd0);

`ifdef CDC_HS_RX_TIMEOUT_EN
      // Watchdog on channel 3 under stall
      out_ready = 1'b0;
      for (int pass = 0; pass < 2; pass++) begin
         issue(3, 8'($urandom));
         n = 0;
         while (pending_o[3] !== 1'b1 && n < 10) begin
            @(posedge clk_dst);
            #1;
            n++;
         end
         n = 0;
         while (timeout_o[3] !== 1'b1 && n < 3 * TO) begin
            @(posedge clk_dst);
            #1;
            n++;
         end
         check("to_latency", 64'(n), 64'(TO));
         #1;
         timeout_clr_i[3] = 1'b1;
         tick();
         timeout_clr_i[3] = 1'b0;
         check("to_clear", 64'(timeout_o[3]), 64'd0);
         repeat (TO + 4) tick();
         check("to_no_reset", 64'(timeout_o[3]), 64'd0);
         out_ready = 1'b1;
         drain("to_drain", 20);
         out_ready = 1'b0;
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cdc_handshake_rx_multi.md
# cdc_handshake_rx_multi

Multi-channel receive endpoint for toggle-based REQ/ACK clock-domain crossings, located entirely in the destination clock domain. It takes `NUM_CH` asynchronous request toggles and data buses and synchronizes each toggle through a configurable-depth chain. Detected requests are arbitrated round-robin onto a single valid/ready output stream, and an ACK toggle is returned per channel once the downstream consumer accepts the word. It succeeds the single-channel fixed-depth toggle handshake and adds:
- width, depth and channel parametrisation
- data capture
- backpressure
- protocol-violation detection

## Interface
Parameters:
- `NUM_CH`, 4: number of independent handshake channels (≥1).
- `DATA_W`, 8: data bits per channel.
- `SYNC_STAGES`, 2: synchronizer flops per request toggle (≥2).
- `TIMEOUT_CYCLES`, 255: watchdog limit. Used only with `CDC_HS_RX_TIMEOUT_EN`.

Ports (`CW` = max(1, clog2(`NUM_CH`))):
- `clk_dst`  in  1  destination clock; the block's only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_toggle_i`  in  `NUM_CH`  asynchronous request toggles, one per channel.
- `data_i`  in  `NUM_CH*DATA_W`  asynchronous data; channel i occupies `[i*DATA_W +: DATA_W]`.
- `ack_toggle_o`  out  `NUM_CH`  ACK toggles returned to the sources.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer accepts the word.
- `out_chan`  out  `CW`  channel index of the output word.
- `out_data`  out  `DATA_W`  captured data.
- `pending_o`  out  `NUM_CH`  request detected, not yet granted.
- `overrun_o`  out  `NUM_CH`  sticky protocol-violation flag.
- `timeout_o`  out  `NUM_CH`  sticky watchdog flag.
- `timeout_clr_i`  in  `NUM_CH`  clears `timeout_o[i]`.

## Operation
- **Source contract:** data is stable before the request toggle flips and is held until the ACK toggle flips. There is one outstanding request per channel.
- **Synchronizer and event detection:**
  - Per channel: a `SYNC_STAGES`-flop synchronizer plus one history flop.
  - event[i] = last sync flop XOR history.
- **Per-channel state:** IDLE → PEND (event; `pending_o[i]` is set) → HELD (granted: data captured into the output register, `pending_o[i]` cleared) → IDLE (on `out_valid && out_ready`, `ack_toggle_o[i]` inverts).
- **Arbitration:**
  - Output register states are EMPTY and FULL.
  - A grant is issued when the register is EMPTY, or when it is FULL and accepted in the current cycle (back-to-back).
  - The round-robin pointer starts at the channel after the last grant; after reset, channel 0 has highest priority.
- **Output stability:** while `out_valid` is high, `out_chan` and `out_data` hold.
- **Overrun:**
  - An event on a channel already in PEND or HELD sets `overrun_o[i]`; that event is discarded and the state is unchanged.
  - The flag is cleared only by reset.
- **Reset values:** all outputs, synchronizers, history flops, pointer and flags are 0.
- **Reset mid-transfer:** the word in flight is dropped and no ACK is issued. Sources must share the reset so that toggle levels realign to 0.

## Timing
- **Event latency:** a toggle first sampled at edge k sets `pending_o` at edge k+`SYNC_STAGES` (±1 cycle from metastability resolution).
- **Grant:** `out_valid` rises one edge after `pending_o`, if the register is free.
- **ACK:** `ack_toggle_o[i]` flips at the same edge that completes the accept.
- **Throughput:** one word per cycle when `out_ready` is held high and multiple channels are pending.
- **Simultaneous events:** events on several channels in one cycle are all latched as pending and served in round-robin order.

## Configuration
- **With `CDC_HS_RX_TIMEOUT_EN` defined:**
  - Each channel has a saturating counter that increments each cycle the channel is in PEND or HELD, and resets to 0 on return to IDLE.
  - When the count reaches `TIMEOUT_CYCLES`, `timeout_o[i]` is set (sticky).
  - `timeout_clr_i[i]` clears the flag; if set and clear occur in the same cycle, set wins.
- **Without the macro:** no counters are built, `timeout_o` is tied to 0, and `timeout_clr_i` is ignored.

## Test plan
- **Single request:** reset, then flip `req_toggle_i[0]` with `data_i[7:0]`=8'hA5 and `out_ready`=1 → `pending_o[0]` rises after 2 cycles (±1), then `out_valid`=1 with `out_chan`=0 and `out_data`=A5, and `ack_toggle_o[0]`=1 on the same accept edge.
- **All channels at once:** flip channels 0–3 in the same cycle with `out_ready`=1 → four consecutive words in order 0,1,2,3 with no bubbles; each ACK flips exactly once.
- **Backpressure:** hold `out_ready`=0 for 10 cycles with channel 2 pending → `out_valid`, `out_chan`=2 and the data stay constant and no ACK flips; release → accept on the next edge.
- **Overrun:** flip `req_toggle_i[1]` twice before its ACK → `overrun_o[1]`=1, only one word is delivered, and other channels are unaffected.
- **Reset mid-transfer:** assert `rst` while `out_valid`=1 → all outputs are 0 in the same cycle, with no spurious event after release.
- **Timeout (macro on, `TIMEOUT_CYCLES`=16):** channel 3 pending with `out_ready`=0 → `timeout_o[3]`=1 after 16 cycles; pulse `timeout_clr_i[3]` → flag clears, and it sets again only after a fresh 16-cycle stall.
